// File: rtl/arbhot_rr_pkg.sv
// -----------------------------------------------------------------------------
// arbhot_rr_pkg
// Shared definitions for the round-robin arbiter family:
//   - clog2        : pointer width helper (never returns less than 1)
//   - slot_state_e : EMPTY/FULL view of the single output slot
//   - RST_*        : reset values for the priority pointer and the output slot
// -----------------------------------------------------------------------------
package arbhot_rr_pkg;

    // Width needed to index n items; a minimum of 1 keeps ptr a real vector
    // even for the smallest legal arbiter (N=2).
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int   RST_PTR       = 0;
    localparam logic RST_OUT_VALID = 1'b0;
    // Fill bit used for the data and select words of the slot on reset.
    localparam logic RST_FILL      = 1'b0;

endpackage

// File: rtl/arbhot_rr_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_req starting at index i_ptr,
// wrapping modulo N; the first set bit wins.
// Ports:
//   i_req    [N]  request vector
//   i_ptr    [PW] index with highest priority this cycle
//   o_grant  [N]  one-hot grant, all-zero when no request is set
//   o_winner [PW] index of the granted bit (0 when o_grant is zero)
// -----------------------------------------------------------------------------
module rr_pick
    import arbhot_rr_pkg::*;
#(
    parameter int N  = 16,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_winner
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_rel_oh;

    // Rotate right by ptr so that relative position 0 is the priority index.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = i_req[(j + int'(i_ptr)) % N];
        end
    end

    // Fixed-priority find-first-set: isolate the lowest set bit.
    assign w_rel_oh = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});

    // Rotate the one-hot result back left by ptr and encode its index.
    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        for (int j = 0; j < N; j++) begin
            if (w_rel_oh[j]) begin
                o_grant[(j + int'(i_ptr)) % N] = 1'b1;
                o_winner = PW'((j + int'(i_ptr)) % N);
            end
        end
    end

endmodule

// File: rtl/arbhot_rr.sv
// -----------------------------------------------------------------------------
// arbhot_rr
// Round-robin arbiter over N valid/ready channels with a single registered
// output slot. Each cycle the slot can load, one requester is picked and its
// data is captured together with a one-hot select for the downstream one-hot
// mux. out_sel is always one-hot or zero.
// Ports:
//   clk        clock, all state on rising edge
//   nreset     asynchronous active-low reset
//   in_valid   [N]     per-channel request
//   in_data    [N*DW]  concatenated channel data, channel 0 in the LSBs
//   in_ready   [N]     per-channel accept, at most one bit set
//   out_valid          slot holds a valid word
//   out_ready          downstream accepts the slot word
//   out_data   [DW]    registered data of the granted channel
//   out_sel    [N]     registered one-hot grant matching out_data
// -----------------------------------------------------------------------------
module arbhot_rr
    import arbhot_rr_pkg::*;
#(
    parameter int DW = 64,
    parameter int N  = 16
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [N-1:0]    out_sel
);

    localparam int PW = clog2(N);

    logic [PW-1:0] r_ptr;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [N-1:0]  r_out_sel;

    slot_state_e   w_slot_state;
    logic          w_load;
    logic [N-1:0]  w_grant;
    logic [PW-1:0] w_winner;
    logic          w_any;
    logic [PW-1:0] w_ptr_next;
    logic [DW-1:0] w_slice [N];
    logic [DW-1:0] w_sel_data;

    assign w_slot_state = r_out_valid ? SLOT_FULL : SLOT_EMPTY;

    // The slot can take a new word when it is empty or is being drained now.
    assign w_load = (w_slot_state == SLOT_EMPTY) | out_ready;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_req    (in_valid),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    assign w_any    = |w_grant;
    assign in_ready = w_grant & {N{w_load}};

    // Explicit wrap keeps the pointer in 0..N-1 for non-power-of-two N.
    assign w_ptr_next = (w_winner == PW'(N - 1)) ? '0 : (w_winner + PW'(1));

    // AND-OR data select; the grant is one-hot so at most one slice survives.
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign w_slice[gi] = in_data[gi*DW +: DW] & {DW{w_grant[gi]}};
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            w_sel_data = w_sel_data | w_slice[i];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ptr       <= PW'(RST_PTR);
            r_out_valid <= RST_OUT_VALID;
            r_out_data  <= {DW{RST_FILL}};
            r_out_sel   <= {N{RST_FILL}};
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_sel   <= w_grant;
                r_out_data  <= w_sel_data;
                r_ptr       <= w_ptr_next;
            end else begin
                // Nothing to load: empty the slot, leave data and ptr alone.
                r_out_valid <= 1'b0;
                r_out_sel   <= '0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arbhot_rr.sv
module tb_arbhot_rr;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            nreset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_sel;

    int n_checks;
    int n_errs;

    typedef struct {
        logic [N-1:0]  sel;
        logic [DW-1:0] data;
    } sb_t;

    sb_t sb[$];

    arbhot_rr #(
        .DW (DW),
        .N  (N)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [N-1:0] s, input logic [DW-1:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_sel"},   32'(out_sel),   32'(s));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        $display("step %s: valid=%0b sel=%b data=%02h", tag, out_valid, out_sel, out_data);
    endtask

    initial begin
        logic [N-1:0]  m_grant;
        logic [N-1:0]  exp_ready;
        logic          m_load;
        int            m_ptr;
        int            m_win;
        int            idx;
        int            wait_cnt [N];
        logic [5:0]    ch_cnt [N];
        sb_t           e;
        logic [1:0]    c2;

        n_checks  = 0;
        n_errs    = 0;
        nreset    = 1'b0;
        in_valid  = '0;
        in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sel",   32'(out_sel),   32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        tick();
        nreset = 1'b1;

        // Round-robin rotation with all channels requesting
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rr_ready0", 32'(in_ready), 32'b0001);
        tick(); chk_slot("rr0", 1'b1, 4'b0001, 8'h00);
        chk("rr_ready1", 32'(in_ready), 32'b0010);
        tick(); chk_slot("rr1", 1'b1, 4'b0010, 8'h11);
        chk("rr_ready2", 32'(in_ready), 32'b0100);
        tick(); chk_slot("rr2", 1'b1, 4'b0100, 8'h22);
        chk("rr_ready3", 32'(in_ready), 32'b1000);
        tick(); chk_slot("rr3", 1'b1, 4'b1000, 8'h33);
        tick(); chk_slot("rr4", 1'b1, 4'b0001, 8'h00);

        // Move to slot holding 22/0100 (ptr=3)
        tick(); chk_slot("pre_bp1", 1'b1, 4'b0010, 8'h11);
        tick(); chk_slot("pre_bp2", 1'b1, 4'b0100, 8'h22);

        // Backpressure: slot must hold, no ready offered
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 32'(in_ready), 32'd0);
            tick(); chk_slot("bp_hold", 1'b1, 4'b0100, 8'h22);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b1000);
        tick(); chk_slot("bp_release", 1'b1, 4'b1000, 8'h33);

        // Skip and wrap: bring ptr to 3 via channel 2, then request 0101
        in_valid = 4'b0100;
        #1;
        chk("sk_ready0", 32'(in_ready), 32'b0100);
        tick(); chk_slot("sk0", 1'b1, 4'b0100, 8'h22);
        in_valid = 4'b0101;
        #1;
        chk("sk_ready1", 32'(in_ready), 32'b0001);
        tick(); chk_slot("sk1", 1'b1, 4'b0001, 8'h00);
        chk("sk_ready2", 32'(in_ready), 32'b0100);
        tick(); chk_slot("sk2", 1'b1, 4'b0100, 8'h22);
        chk("sk_ready3", 32'(in_ready), 32'b0001);
        tick(); chk_slot("sk3", 1'b1, 4'b0001, 8'h00);

        // Idle drain: slot empties, ptr stays at 1
        in_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd0);
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_sel",   32'(out_sel),   32'd0);
        in_valid = 4'b1111;
        #1;
        chk("idle_ptr_kept", 32'(in_ready), 32'b0010);
        tick(); chk_slot("idle_after", 1'b1, 4'b0010, 8'h11);

        // Reset mid-operation: immediate clear, ptr back to 0
        nreset = 1'b0;
        #1;
        chk_slot("mid_rst", 1'b0, 4'b0000, 8'h00);
        in_valid = 4'b1000;
        #1;
        nreset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'b1000);
        tick(); chk_slot("mid_rst_first", 1'b1, 4'b1000, 8'h33);

        // Random stress with an independent search model and scoreboard
        m_ptr = 0;
        e.sel = 4'b1000;
        e.data = 8'h33;
        sb.push_back(e);
        in_valid = '0;
        for (int c = 0; c < N; c++) begin
            wait_cnt[c] = 0;
            ch_cnt[c]   = '0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                if (!in_valid[c] && ($urandom_range(0, 1) == 1)) begin
                    c2 = 2'(c);
                    in_valid[c] = 1'b1;
                    in_data[c*DW +: DW] = {c2, ch_cnt[c]};
                    ch_cnt[c] = ch_cnt[c] + 6'd1;
                end
            end
            #1;
            m_load  = !out_valid || out_ready;
            m_grant = '0;
            m_win   = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (in_valid[idx] && (m_grant == '0)) begin
                    m_grant[idx] = 1'b1;
                    m_win = idx;
                end
            end
            exp_ready = m_load ? m_grant : '0;
            chk("st_in_ready", 32'(in_ready), 32'(exp_ready));
            chk("st_sel_onehot0", 32'($onehot0(out_sel)), 32'd1);
            chk("st_rdy_onehot0", 32'($onehot0(in_ready)), 32'd1);
            if (!out_valid) begin
                chk("st_sel_zero", 32'(out_sel), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("st_sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("st_out_sel",  32'(out_sel),  32'(e.sel));
                    chk("st_out_data", 32'(out_data), 32'(e.data));
                end
            end
            if (m_load && (m_grant != '0)) begin
                e.sel  = m_grant;
                e.data = in_data[m_win*DW +: DW];
                sb.push_back(e);
                for (int c = 0; c < N; c++) begin
                    if (in_valid[c] && (c != m_win)) begin
                        wait_cnt[c]++;
                        chk("st_fair", 32'(wait_cnt[c] <= N - 1), 32'd1);
                    end
                end
                wait_cnt[m_win] = 0;
                m_ptr = (m_win + 1) % N;
            end
            tick();
            if (m_load) begin
                in_valid = in_valid & ~m_grant;
            end
        end
        $display("stress: %0d words left in scoreboard", sb.size());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
